// File: rtl/curtain_pkg.sv
// Shared encodings for the curtain motor sequencer: FSM states, brake pending target,
// light classes and the one-hot motor command words.
package curtain_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_OPENING = 3'd1,
        ST_CLOSING = 3'd2,
        ST_BRAKE   = 3'd3,
        ST_FAULT   = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        PEND_NONE  = 2'd0,
        PEND_OPEN  = 2'd1,
        PEND_CLOSE = 2'd2
    } pending_t;

    typedef enum logic [1:0] {
        CLS_NONE   = 2'd0,
        CLS_BRIGHT = 2'd1,
        CLS_DARK   = 2'd2
    } light_cls_t;

    localparam logic [3:0] CTRL_STOP  = 4'b1000;
    localparam logic [3:0] CTRL_BRAKE = 4'b0100;
    localparam logic [3:0] CTRL_FWD   = 4'b0010;
    localparam logic [3:0] CTRL_BWD   = 4'b0001;

    function automatic logic [3:0] ctrl_of(input state_t s);
        case (s)
            ST_OPENING: ctrl_of = CTRL_FWD;
            ST_CLOSING: ctrl_of = CTRL_BWD;
            ST_BRAKE:   ctrl_of = CTRL_BRAKE;
            default:    ctrl_of = CTRL_STOP;
        endcase
    endfunction

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser plus registered rising-edge detector for one raw button.
// A rise before edge N yields a one-cycle pulse registered at edge N+2; no backpressure.
module btn_sync_edge (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic pulse
);

    logic [2:0] sync;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync  <= '0;
            pulse <= 1'b0;
        end else begin
            sync  <= {sync[1:0], raw};
            pulse <= sync[1] & ~sync[2];
        end
    end

endmodule

// File: rtl/curtain_sequencer.sv
// Curtain motor sequencer: buttons, limits and light auto mode drive a one-hot motor command,
// with a timed brake on every stop/reversal and a runaway timeout; button-to-control latency 3 cycles.
module curtain_sequencer
    import curtain_pkg::*;
#(
    parameter int         TICK_DIV      = 50000,
    parameter int         BRAKE_TICKS   = 200,
    parameter int         TIMEOUT_TICKS = 8000,
    parameter int         SETTLE_TICKS  = 500,
    parameter logic [7:0] LIGHT_HI      = 8'd200,
    parameter logic [7:0] LIGHT_LO      = 8'd60
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       btn_open,
    input  logic       btn_close,
    input  logic       btn_stop,
    input  logic       auto_en,
    input  logic [7:0] light_level,
    input  logic       limit_open,
    input  logic       limit_closed,
    output logic [3:0] control,
    output logic [2:0] state,
    output logic       busy,
    output logic       fault
);

    localparam int TMAX = (TIMEOUT_TICKS > BRAKE_TICKS) ? TIMEOUT_TICKS : BRAKE_TICKS;
    localparam int PW   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam int SW   = (SETTLE_TICKS > 1) ? $clog2(SETTLE_TICKS) : 1;

    localparam logic [PW-1:0] PRE_LAST     = PW'(TICK_DIV - 1);
    localparam logic [TW-1:0] BRAKE_LAST   = TW'(BRAKE_TICKS - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_TICKS - 1);
    localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_TICKS - 1);

    logic open_edge, close_edge, stop_edge;

    btn_sync_edge u_open  (.clk(clk), .rst_n(rst_n), .raw(btn_open),  .pulse(open_edge));
    btn_sync_edge u_close (.clk(clk), .rst_n(rst_n), .raw(btn_close), .pulse(close_edge));
    btn_sync_edge u_stop  (.clk(clk), .rst_n(rst_n), .raw(btn_stop),  .pulse(stop_edge));

    state_t        cur_state;
    pending_t      pending;
    light_cls_t    cls, cls_q;
    logic [PW-1:0] pre_cnt;
    logic [TW-1:0] tick_cnt;
    logic [SW-1:0] settle_cnt;

    logic tick, both_lim, open_cmd, close_cmd, settle_run, auto_hit, brake_done;

    always_comb begin
        cls = CLS_NONE;
        if (auto_en) begin
            if (light_level >= LIGHT_HI)      cls = CLS_BRIGHT;
            else if (light_level <= LIGHT_LO) cls = CLS_DARK;
        end
    end

    assign tick       = (pre_cnt == PRE_LAST);
    assign both_lim   = limit_open & limit_closed;
    // Simultaneous open and close presses cancel each other.
    assign open_cmd   = open_edge & ~close_edge;
    assign close_cmd  = close_edge & ~open_edge;
    assign settle_run = (cls != CLS_NONE) && (cls == cls_q);
    assign auto_hit   = settle_run && tick && (settle_cnt == SETTLE_LAST);
    assign brake_done = tick && (tick_cnt == BRAKE_LAST);

    // Any assignment to cur_state below also restarts the prescaler and tick counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state  <= ST_IDLE;
            pending    <= PEND_NONE;
            cls_q      <= CLS_NONE;
            pre_cnt    <= '0;
            tick_cnt   <= '0;
            settle_cnt <= '0;
        end else begin
            cls_q      <= cls;
            pre_cnt    <= tick ? '0 : pre_cnt + 1'b1;
            settle_cnt <= '0;
            if (tick && tick_cnt != '1) tick_cnt <= tick_cnt + 1'b1;

            case (cur_state)
                ST_IDLE: begin
                    // Settle timing starts afresh whenever the light class changes.
                    if (settle_run) begin
                        if (tick && settle_cnt != SETTLE_LAST) settle_cnt <= settle_cnt + 1'b1;
                        else                                   settle_cnt <= settle_cnt;
                    end else begin
                        pre_cnt <= '0;
                    end
                    if (!stop_edge) begin
                        if (both_lim) begin
                            cur_state <= ST_FAULT; pre_cnt <= '0; tick_cnt <= '0; settle_cnt <= '0;
                        end else if (open_cmd && !limit_open) begin
                            cur_state <= ST_OPENING; pre_cnt <= '0; tick_cnt <= '0; settle_cnt <= '0;
                        end else if (close_cmd && !limit_closed) begin
                            cur_state <= ST_CLOSING; pre_cnt <= '0; tick_cnt <= '0; settle_cnt <= '0;
                        end else if (auto_hit && cls == CLS_BRIGHT && !limit_closed) begin
                            cur_state <= ST_CLOSING; pre_cnt <= '0; tick_cnt <= '0; settle_cnt <= '0;
                        end else if (auto_hit && cls == CLS_DARK && !limit_open) begin
                            cur_state <= ST_OPENING; pre_cnt <= '0; tick_cnt <= '0; settle_cnt <= '0;
                        end
                    end
                end
                ST_OPENING, ST_CLOSING: begin
                    if (stop_edge ||
                        (!both_lim && (cur_state == ST_OPENING ? limit_open : limit_closed))) begin
                        cur_state <= ST_BRAKE; pending <= PEND_NONE; pre_cnt <= '0; tick_cnt <= '0;
                    end else if (both_lim || (tick && tick_cnt == TIMEOUT_LAST)) begin
                        cur_state <= ST_FAULT; pre_cnt <= '0; tick_cnt <= '0;
                    end else if (cur_state == ST_OPENING && close_cmd) begin
                        cur_state <= ST_BRAKE; pending <= PEND_CLOSE; pre_cnt <= '0; tick_cnt <= '0;
                    end else if (cur_state == ST_CLOSING && open_cmd) begin
                        cur_state <= ST_BRAKE; pending <= PEND_OPEN; pre_cnt <= '0; tick_cnt <= '0;
                    end
                end
                ST_BRAKE: begin
                    // A stop landing on the final brake tick still ends the brake, into IDLE.
                    if (both_lim && !stop_edge) begin
                        cur_state <= ST_FAULT; pre_cnt <= '0; tick_cnt <= '0;
                    end else if (brake_done) begin
                        pre_cnt  <= '0;
                        tick_cnt <= '0;
                        if (!stop_edge && pending == PEND_OPEN && !limit_open)          cur_state <= ST_OPENING;
                        else if (!stop_edge && pending == PEND_CLOSE && !limit_closed)  cur_state <= ST_CLOSING;
                        else                                                            cur_state <= ST_IDLE;
                    end else if (stop_edge) begin
                        pending <= PEND_NONE;
                    end else if (open_cmd) begin
                        pending <= PEND_OPEN;
                    end else if (close_cmd) begin
                        pending <= PEND_CLOSE;
                    end
                end
                ST_FAULT: begin
                    if (stop_edge && !both_lim) begin
                        cur_state <= ST_IDLE; pre_cnt <= '0; tick_cnt <= '0;
                    end
                end
                default: begin
                    cur_state <= ST_IDLE; pre_cnt <= '0; tick_cnt <= '0;
                end
            endcase
        end
    end

    assign state   = cur_state;
    assign control = ctrl_of(cur_state);
    assign busy    = (cur_state == ST_OPENING) || (cur_state == ST_CLOSING) || (cur_state == ST_BRAKE);
    assign fault   = (cur_state == ST_FAULT);

endmodule

// File: tb/tb_curtain_sequencer.sv
// Directed bench for curtain_sequencer with small timer parameters; expected
// states are queued as stimulus is applied and popped when the output is due.
module tb_curtain_sequencer;

    localparam logic [2:0] S_IDLE = 3'd0, S_OPEN = 3'd1, S_CLOSE = 3'd2, S_BRAKE = 3'd3, S_FAULT = 3'd4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       btn_open, btn_close, btn_stop, auto_en;
    logic [7:0] light_level;
    logic       limit_open, limit_closed;
    logic [3:0] control;
    logic [2:0] state;
    logic       busy, fault;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string      tag;
        logic [2:0] st;
    } exp_t;

    exp_t sb_q[$];

    always #5 clk = ~clk;

    curtain_sequencer #(
        .TICK_DIV(4), .BRAKE_TICKS(2), .TIMEOUT_TICKS(20), .SETTLE_TICKS(3),
        .LIGHT_HI(8'd200), .LIGHT_LO(8'd60)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .btn_open(btn_open), .btn_close(btn_close), .btn_stop(btn_stop),
        .auto_en(auto_en), .light_level(light_level),
        .limit_open(limit_open), .limit_closed(limit_closed),
        .control(control), .state(state), .busy(busy), .fault(fault)
    );

    // Reference decode of the expected outputs for a given state.
    function automatic logic [8:0] model_out(input logic [2:0] st);
        case (st)
            S_OPEN:  model_out = {4'b0010, st, 1'b1, 1'b0};
            S_CLOSE: model_out = {4'b0001, st, 1'b1, 1'b0};
            S_BRAKE: model_out = {4'b0100, st, 1'b1, 1'b0};
            S_FAULT: model_out = {4'b1000, st, 1'b0, 1'b1};
            default: model_out = {4'b1000, st, 1'b0, 1'b0};
        endcase
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input int which);
        case (which)
            0:       btn_open  = 1'b1;
            1:       btn_close = 1'b1;
            default: btn_stop  = 1'b1;
        endcase
        @(negedge clk);
        btn_open  = 1'b0;
        btn_close = 1'b0;
        btn_stop  = 1'b0;
    endtask

    task automatic expect_state(input string tag, input logic [2:0] st);
        exp_t e;
        e.tag = tag;
        e.st  = st;
        sb_q.push_back(e);
    endtask

    task automatic check_next();
        exp_t       e;
        logic [8:0] want, got;
        n_checks++;
        if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: observed no queued expectation, required one");
        end else begin
            e    = sb_q.pop_front();
            want = model_out(e.st);
            got  = {control, state, busy, fault};
            assert (got === want) else begin
                n_fail++;
                $error("FAIL %s: observed ctrl=%b st=%0d busy=%b fault=%b, expected ctrl=%b st=%0d busy=%b fault=%b",
                       e.tag, got[8:5], got[4:2], got[1], got[0], want[8:5], want[4:2], want[1], want[0]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, required finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0; btn_open = 1'b0; btn_close = 1'b0; btn_stop = 1'b0;
        auto_en = 1'b0; light_level = 8'd128; limit_open = 1'b0; limit_closed = 1'b0;
        step(2);
        expect_state("reset", S_IDLE); check_next();
        rst_n = 1'b1;
        step(1);

        // 1: open, limit stop, 8-cycle brake
        press(0);
        expect_state("t1_open_pre", S_IDLE);  step(2); check_next();
        expect_state("t1_open",     S_OPEN);  step(1); check_next();
        limit_open = 1'b1;
        expect_state("t1_brk_first", S_BRAKE); step(1); check_next();
        expect_state("t1_brk_last",  S_BRAKE); step(7); check_next();
        expect_state("t1_idle",      S_IDLE);  step(1); check_next();
        limit_open = 1'b0;

        // 2: reversal through brake, then stop during brake
        press(1);
        expect_state("t2_close",     S_CLOSE); step(3); check_next();
        press(0);
        expect_state("t2_rev_pre",   S_CLOSE); step(2); check_next();
        expect_state("t2_rev_brk",   S_BRAKE); step(1); check_next();
        expect_state("t2_brk_last",  S_BRAKE); step(7); check_next();
        expect_state("t2_to_open",   S_OPEN);  step(1); check_next();
        press(1);
        expect_state("t2_brk2",      S_BRAKE); step(3); check_next();
        press(2);
        expect_state("t2_stop_brk",  S_BRAKE); step(6); check_next();
        expect_state("t2_stop_idle", S_IDLE);  step(1); check_next();
        expect_state("t2_idle_hold", S_IDLE);  step(4); check_next();

        // 3: runaway timeout and fault recovery
        press(0);
        expect_state("t3_open",      S_OPEN);  step(3);  check_next();
        expect_state("t3_open_last", S_OPEN);  step(79); check_next();
        expect_state("t3_fault",     S_FAULT); step(1);  check_next();
        press(0);
        expect_state("t3_ignore",    S_FAULT); step(4);  check_next();
        press(2);
        expect_state("t3_stop_pre",  S_FAULT); step(2);  check_next();
        expect_state("t3_clear",     S_IDLE);  step(1);  check_next();

        // 4: auto close after settle, and settle restart after a dip
        auto_en = 1'b1; light_level = 8'd210;
        step(1);
        expect_state("t4_settle",     S_IDLE);  step(11); check_next();
        expect_state("t4_auto_close", S_CLOSE); step(1);  check_next();
        light_level = 8'd128; auto_en = 1'b0;
        press(2);
        expect_state("t4_stopped",    S_IDLE);  step(11); check_next();
        auto_en = 1'b1; light_level = 8'd210;
        step(6);
        light_level = 8'd100;
        step(1);
        light_level = 8'd210;
        step(1);
        expect_state("t4_dip_hold",   S_IDLE);  step(11); check_next();
        expect_state("t4_dip_close",  S_CLOSE); step(1);  check_next();
        light_level = 8'd128; auto_en = 1'b0;
        press(2);
        expect_state("t4_dip_stopped", S_IDLE); step(11); check_next();

        // 5: commands toward asserted limits, and both limits
        limit_closed = 1'b1;
        press(1);
        expect_state("t5_close_blocked", S_IDLE);  step(4);  check_next();
        auto_en = 1'b1; light_level = 8'd210;
        expect_state("t5_auto_blocked",  S_IDLE);  step(20); check_next();
        light_level = 8'd128; auto_en = 1'b0; limit_closed = 1'b0;
        press(0);
        expect_state("t5_open",          S_OPEN);  step(3);  check_next();
        limit_open = 1'b1; limit_closed = 1'b1;
        expect_state("t5_both_fault",    S_FAULT); step(1);  check_next();
        press(2);
        expect_state("t5_stop_held",     S_FAULT); step(4);  check_next();
        limit_open = 1'b0; limit_closed = 1'b0;
        press(2);
        expect_state("t5_recover",       S_IDLE);  step(3);  check_next();

        // 6: asynchronous reset while closing
        press(1);
        expect_state("t6_close", S_CLOSE); step(3); check_next();
        #2;
        rst_n = 1'b0;
        #1;
        expect_state("t6_async", S_IDLE); check_next();
        @(negedge clk);
        rst_n = 1'b1;
        expect_state("t6_after", S_IDLE); step(2); check_next();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/curtain_sequencer.md
Name: curtain_sequencer

Overview:
Controller that drives the 4-bit one-hot `control` input of the curtain motor block.
It arbitrates between manual buttons, limit switches and the light-sensor auto mode.
It inserts a timed brake phase at every stop and every direction change, and detects runaway travel with a timeout.
It sits between the sensor/button front end and the motor block: its `control` output connects directly to the motor's `control` input.

Parameters:
TICK_DIV, 50000, clk cycles per timer tick (1 ms at 50 MHz)
BRAKE_TICKS, 200, ticks spent in BRAKE
TIMEOUT_TICKS, 8000, max ticks in OPENING/CLOSING before FAULT
SETTLE_TICKS, 500, ticks a light condition must persist before auto action
LIGHT_HI, 8'd200, light_level at or above this closes the curtain (auto)
LIGHT_LO, 8'd60, light_level at or below this opens the curtain (auto); LIGHT_LO < LIGHT_HI required

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
btn_open  input  1  raw open button, active-high, asynchronous
btn_close  input  1  raw close button, active-high, asynchronous
btn_stop  input  1  raw stop button, active-high, asynchronous
auto_en  input  1  enables light-driven operation (level, synchronous)
light_level  input  8  sensor reading (synchronous)
limit_open  input  1  fully-open switch, active-high (synchronous)
limit_closed  input  1  fully-closed switch, active-high (synchronous)
control  output  4  one-hot motor command: [3]=stop, [2]=brake, [1]=forward/open, [0]=backward/close
state  output  3  current FSM state code
busy  output  1  high in OPENING, CLOSING, BRAKE
fault  output  1  high in FAULT

Behaviour:
- Clock and reset: one clock `clk`; reset `rst_n` is asynchronous and active-low.
- Reset values: state=IDLE, control=4'b1000, busy=0, fault=0. All counters and synchronisers are cleared.
- Button conditioning: each button passes through a 2-flop synchroniser and rising-edge detector. Edge pulses last one cycle.
- Button latency: a button rising before clk edge N updates state/control at edge N+3.
- Output decode: control, busy and fault decode combinationally from the registered state.
  - IDLE → 1000
  - OPENING → 0010
  - CLOSING → 0001
  - BRAKE → 0100
  - FAULT → 1000
- Tick prescaler: counts 0..TICK_DIV-1 and emits a one-cycle tick. It restarts at 0 on every state transition, so BRAKE lasts exactly BRAKE_TICKS*TICK_DIV cycles.
- Command priority within a cycle: stop_edge > limit/timeout > manual open/close edge > auto request. If open and close edges coincide, both are ignored.
- States: IDLE, OPENING, CLOSING, BRAKE, FAULT. BRAKE holds a registered `pending` field: NONE, OPEN or CLOSE.
- IDLE transitions:
  - open edge and !limit_open → OPENING.
  - close edge and !limit_closed → CLOSING.
  - A command toward an already-asserted limit is ignored.
- OPENING/CLOSING transitions:
  - stop_edge → BRAKE (pending=NONE).
  - Own-direction limit asserted → BRAKE (pending=NONE).
  - Opposite-direction command → BRAKE (pending=that direction).
  - Same-direction command → ignored.
  - Run tick count reaches TIMEOUT_TICKS → FAULT.
- BRAKE transitions:
  - After BRAKE_TICKS ticks → OPENING/CLOSING per `pending`, or IDLE if pending=NONE or the target limit is asserted.
  - stop_edge during BRAKE sets pending=NONE; the brake does not restart.
  - A new direction command during BRAKE overwrites pending.
- FAULT transitions:
  - Entered from any state when limit_open && limit_closed.
  - Also entered on timeout.
  - Exited only by stop_edge with the limits not both asserted → IDLE.
  - All other commands are ignored in FAULT.
- Auto mode: evaluated only in IDLE with auto_en=1.
  - Settle counter counts ticks while light_level >= LIGHT_HI (bright) or <= LIGHT_LO (dark).
  - The counter clears when the condition class changes, when the level enters the hysteresis band, or when auto_en=0.
  - Bright for SETTLE_TICKS and !limit_closed → CLOSING.
  - Dark for SETTLE_TICKS and !limit_open → OPENING.
  - The settle counter clears on leaving IDLE.
- Width rules: counters are sized by $clog2 of their parameter and saturate at terminal count; they never wrap.
- Reset mid-operation: control returns to 1000 asynchronously. No brake phase is issued.

Decomposition:
- Package `curtain_pkg`:
  - State encoding: IDLE=0, OPENING=1, CLOSING=2, BRAKE=3, FAULT=4.
  - Pending encoding.
  - Control constants: CTRL_STOP=4'b1000, CTRL_BRAKE=4'b0100, CTRL_FWD=4'b0010, CTRL_BWD=4'b0001.
- Sub-module `btn_sync_edge`: 2-flop synchroniser plus rising-edge pulse. Instantiated once per button.

Test Plan:
All tests use TICK_DIV=4, BRAKE_TICKS=2, TIMEOUT_TICKS=20, SETTLE_TICKS=3.
1. Reset then btn_open pulse → control=0010 three cycles after the pulse. Raise limit_open → control=0100 for exactly 8 cycles, then 1000 and busy=0.
2. While CLOSING, pulse btn_open → control=0001 → 0100 (8 cycles) → 0010. Pulse btn_stop during the brake → returns to 1000 after the brake, not 0010.
3. OPENING with no limit → control=0010 for 80 cycles → FAULT, control=1000, fault=1. btn_open ignored; btn_stop → IDLE, fault=0.
4. auto_en=1, light_level=210 held 12 cycles → CLOSING. Repeat with a dip to 100 mid-settle → no motion until 12 uninterrupted cycles.
5. limit_closed=1 and btn_close, or auto bright → stays IDLE. Assert limit_open and limit_closed together while OPENING → FAULT next cycle.
6. Deassert rst_n while CLOSING → control=1000 immediately, without waiting for a clk edge. State=IDLE after release.
